// File: rtl/jt49_env_gen.sv
// jt49_env_gen: YM2149-style 32-step envelope generator with period divider and CONT/ATT/ALT/HOLD shapes
module jt49_env_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [15:0] eg_period,
  input  logic [3:0]  eg_shape,
  input  logic        eg_restart,
  output logic [4:0]  env,
  output logic        env_step,
  output logic        env_held
);
  typedef enum logic {RUN, HOLD} st_t;
  st_t         st, st_n;
  logic [15:0] cnt, cnt_n;
  logic [4:0]  base, base_n, base_inc, env_n;
  logic        dir, dir_n, step_n;
  logic [15:0] per;
  logic        cont, att, alt, hold, tc;
  assign {cont, att, alt, hold} = eg_shape;
  assign per      = (eg_period == 16'd0) ? 16'd1 : eg_period;
  assign tc       = cnt >= per - 16'd1;
  assign base_inc = base + 5'd1;
  assign env_held = (st == HOLD);
  // state register: divider, step counter, direction, level and step strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= HOLD;
      cnt      <= '0;
      base     <= '0;
      dir      <= 1'b0;
      env      <= '0;
      env_step <= 1'b0;
    end else begin
      st       <= st_n;
      cnt      <= cnt_n;
      base     <= base_n;
      dir      <= dir_n;
      env      <= env_n;
      env_step <= step_n;
    end
  end
  // next state: restart wins over a coincident tick; end of cycle resolved by shape bits
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    base_n = base;
    dir_n  = dir;
    env_n  = env;
    step_n = 1'b0;
    if (eg_restart) begin
      st_n   = RUN;
      cnt_n  = '0;
      base_n = '0;
      dir_n  = att;
      env_n  = att ? 5'd0 : 5'd31;
    end else if (st == RUN && cen) begin
      if (!tc) begin
        cnt_n = cnt + 16'd1;
      end else begin
        cnt_n  = '0;
        step_n = 1'b1;
        if (base != 5'd31) begin
          base_n = base_inc;
          env_n  = dir ? base_inc : ~base_inc;
        end else if (!cont) begin
          st_n  = HOLD;
          env_n = 5'd0;
        end else if (hold) begin
          st_n  = HOLD;
          env_n = (att ^ alt) ? 5'd31 : 5'd0;
        end else begin
          base_n = '0;
          dir_n  = dir ^ alt;
          env_n  = (dir ^ alt) ? 5'd0 : 5'd31;
        end
      end
    end
  end
endmodule

// File: tb/tb_jt49_env_gen.sv
// tb_jt49_env_gen: scoreboard bench comparing the envelope generator against a cycle model
module tb_jt49_env_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [15:0] eg_period = '0;
  logic [3:0]  eg_shape = '0;
  logic        eg_restart = 1'b0;
  logic [4:0]  env;
  logic        env_step, env_held;

  jt49_env_gen dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .eg_period(eg_period),
    .eg_shape(eg_shape), .eg_restart(eg_restart),
    .env(env), .env_step(env_step), .env_held(env_held)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int steps = 0;
  logic [6:0] sb[$];

  // reference model state
  int m_cnt, m_base, m_env;
  bit m_dir, m_held, m_step;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got env=%0d step=%0b held=%0b, want env=%0d step=%0b held=%0b",
                tag, obs[6:2], obs[1], obs[0], exp[6:2], exp[1], exp[0]);
  endtask

  task automatic model();
    int p;
    m_step = 0;
    if (!rst_n) begin
      m_cnt = 0; m_base = 0; m_dir = 0; m_held = 1; m_env = 0;
    end else if (eg_restart) begin
      m_cnt = 0; m_base = 0; m_dir = eg_shape[2]; m_held = 0;
      m_env = eg_shape[2] ? 0 : 31;
    end else if (!m_held && cen) begin
      p = (eg_period == 0) ? 1 : int'(eg_period);
      if (m_cnt < p - 1) m_cnt++;
      else begin
        m_cnt = 0;
        m_step = 1;
        if (m_base < 31) begin
          m_base++;
          m_env = m_dir ? m_base : 31 - m_base;
        end else if (!eg_shape[3]) begin
          m_held = 1; m_env = 0;
        end else if (eg_shape[0]) begin
          m_held = 1; m_env = (eg_shape[2] ^ eg_shape[1]) ? 31 : 0;
        end else begin
          m_base = 0;
          if (eg_shape[1]) m_dir = !m_dir;
          m_env = m_dir ? 0 : 31;
        end
      end
    end
  endtask

  // drive one cycle, push model expectation, compare DUT output after the edge
  task automatic tick(input string tag, input bit r, input bit c, input bit rs);
    logic [6:0] exp;
    rst_n = r; cen = c; eg_restart = rs;
    model();
    sb.push_back({5'(m_env), m_step, m_held});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check(tag, {env, env_step, env_held}, exp);
    if (env_step) steps++;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1, 1, 0);
  endtask

  task automatic restart(input string tag, input logic [15:0] p, input logic [3:0] s);
    eg_period = p; eg_shape = s;
    tick(tag, 1, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    tick("reset", 0, 0, 0);
    tick("reset2", 0, 1, 0);
    steps = 0;
    run("idle", 100);
    check("idle_steps", 7'(steps), 7'd0);

    restart("att_hold_rst", 16'd2, 4'b1101);
    check("att_start", {env, env_step, env_held}, {5'd0, 1'b0, 1'b0});
    run("att_hold", 64 + 200);
    check("att_final", {env, env_step, env_held}, {5'd31, 1'b0, 1'b1});

    restart("tri_rst", 16'd1, 4'b1010);
    for (int i = 0; i < 150; i++) tick("tri", 1, 1'($urandom_range(0, 3) != 0), 0);

    restart("p0_rst", 16'd0, 4'b0000);
    steps = 0;
    run("p0", 40);
    check("p0_steps", 7'(steps), 7'd32);
    check("p0_final", {env, env_step, env_held}, {5'd0, 1'b0, 1'b1});

    restart("s1011_rst", 16'd1, 4'b1011);
    run("s1011", 40);
    check("s1011_final", {env, env_step, env_held}, {5'd31, 1'b0, 1'b1});
    restart("s1111_rst", 16'd1, 4'b1111);
    run("s1111", 40);
    check("s1111_final", {env, env_step, env_held}, {5'd0, 1'b0, 1'b1});
    restart("saw_rst", 16'd1, 4'b1000);
    run("saw", 80);

    restart("coinc_pre", 16'd1, 4'b1000);
    run("coinc_run", 5);
    eg_shape = 4'b1101;
    tick("coinc", 1, 1, 1);
    check("coinc_env", {env, env_step, env_held}, {5'd0, 1'b0, 1'b0});
    eg_period = 16'd3;
    run("coinc_after", 6);

    restart("lower_rst", 16'd100, 4'b1100);
    run("lower_run", 50);
    eg_period = 16'd3;
    tick("lower_step", 1, 1, 0);
    check("lower_strobe", {env, env_step, env_held}, {5'd1, 1'b1, 1'b0});
    run("lower_after", 10);

    restart("midrst_rst", 16'd2, 4'b1101);
    run("midrst_ramp", 20);
    tick("midrst", 0, 1, 0);
    check("midrst_state", {env, env_step, env_held}, {5'd0, 1'b0, 1'b1});
    tick("midrst_hold", 1, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
